saida_serial_multidigito: RTL and testbench

Parametrised serial output sequencer. It latches an N-digit packed BCD value on `inicio` and converts each digit to ASCII. It then hands the characters one at a time, most significant digit first, to the serial transmitter through a `partida`/`serial_enviado` handshake, and closes the frame with a terminator character. It sits between the measurement datapath and the serial TX block and replaces the fixed three-digit-plus-`#` sequencer, adding digit-count generalisation, optional leading-zero suppression and invalid-digit signalling.

---
 rtl/saida_serial_multidigito.sv | 164 ++++++++++++++++
 tb/tb_saida_serial_multidigito.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/saida_serial_multidigito.sv
// saida_serial_multidigito: serial output sequencer. It latches an N-digit packed
// BCD value and sends one ASCII character per handshake, most significant digit
// first, then the terminator. Leading zeros can be suppressed, and invalid digits
// are sent as '?'.
// Optional feature: define SAIDA_SERIAL_CRLF_EN to append CR and LF after the terminator.
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   inicio              - frame request, accepted only while idle
//   dados               - packed BCD, most significant digit in the top nibble
//   suprime_zeros       - leading-zero suppression enable, latched with dados
//   serial_enviado      - transmitter done pulse
//   partida             - one-cycle transmit request for dado_serial
//   dado_serial         - registered ASCII character
//   ocupado / pronto    - frame in progress / one-cycle frame-complete pulse
//   db_estado           - current state code
module saida_serial_multidigito #(
    parameter int unsigned N_DIGITOS  = 3,
    parameter logic [7:0]  TERMINADOR = 8'h23
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inicio,
    input  logic [4*N_DIGITOS-1:0] dados,
    input  logic                   suprime_zeros,
    input  logic                   serial_enviado,
    output logic                   partida,
    output logic [7:0]             dado_serial,
    output logic                   ocupado,
    output logic                   pronto,
    output logic [3:0]             db_estado
);

    localparam int unsigned DW = 4 * N_DIGITOS;
    localparam int unsigned PW = $clog2(N_DIGITOS + 3);
`ifdef SAIDA_SERIAL_CRLF_EN
    localparam int unsigned ULTIMO = N_DIGITOS + 2;
`else
    localparam int unsigned ULTIMO = N_DIGITOS;
`endif

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        PREPARA = 4'd1,
        ENVIA   = 4'd2,
        ESPERA  = 4'd3,
        FIM     = 4'd4
    } estado_t;

    estado_t         estado_q, estado_d;
    logic [PW-1:0]   pos_q, pos_d;
    logic            lider_q, lider_d;
    logic [DW-1:0]   dados_q, dados_d;
    logic            supr_q, supr_d;
    logic [7:0]      dado_serial_q, dado_serial_d;

    logic            e_digito;
    logic [DW-1:0]   deslocado;
    logic [3:0]      digito;
    logic [7:0]      caractere;
    logic            pular;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q      <= INICIAL;
            pos_q         <= '0;
            lider_q       <= 1'b0;
            dados_q       <= '0;
            supr_q        <= 1'b0;
            dado_serial_q <= 8'h00;
        end else begin
            estado_q      <= estado_d;
            pos_q         <= pos_d;
            lider_q       <= lider_d;
            dados_q       <= dados_d;
            supr_q        <= supr_d;
            dado_serial_q <= dado_serial_d;
        end
    end

    // Character for the current position; the digit index counts down from the MSD
    always_comb begin
        e_digito  = (pos_q < PW'(N_DIGITOS));
        deslocado = '0;
        if (e_digito) begin
            deslocado = dados_q >> (4 * (N_DIGITOS - 1 - 32'(pos_q)));
        end
        digito    = deslocado[3:0];
        caractere = TERMINADOR;
        if (e_digito) begin
            caractere = (digito <= 4'd9) ? (8'h30 + {4'h0, digito}) : 8'h3F;
        end
`ifdef SAIDA_SERIAL_CRLF_EN
        else if (pos_q == PW'(N_DIGITOS + 1)) begin
            caractere = 8'h0D;
        end else if (pos_q == PW'(N_DIGITOS + 2)) begin
            caractere = 8'h0A;
        end
`endif
        // Last digit is never skipped, so an all-zero value still sends '0'
        pular = e_digito && (digito == 4'd0) && supr_q && lider_q
                && (pos_q < PW'(N_DIGITOS - 1));
    end

    // Next-state and Moore outputs
    always_comb begin
        estado_d      = estado_q;
        pos_d         = pos_q;
        lider_d       = lider_q;
        dados_d       = dados_q;
        supr_d        = supr_q;
        dado_serial_d = dado_serial_q;
        partida       = 1'b0;
        pronto        = 1'b0;
        ocupado       = 1'b1;
        unique case (estado_q)
            INICIAL: begin
                ocupado = 1'b0;
                if (inicio) begin
                    dados_d  = dados;
                    supr_d   = suprime_zeros;
                    pos_d    = '0;
                    lider_d  = 1'b1;
                    estado_d = PREPARA;
                end
            end
            PREPARA: begin
                if (pular) begin
                    pos_d = pos_q + PW'(1);
                end else begin
                    dado_serial_d = caractere;
                    lider_d       = 1'b0;
                    estado_d      = ENVIA;
                end
            end
            ENVIA: begin
                partida  = 1'b1;
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (serial_enviado) begin
                    if (pos_q == PW'(ULTIMO)) begin
                        estado_d = FIM;
                    end else begin
                        pos_d    = pos_q + PW'(1);
                        estado_d = PREPARA;
                    end
                end
            end
            FIM: begin
                pronto   = 1'b1;
                estado_d = INICIAL;
            end
            default: begin
                ocupado  = 1'b0;
                estado_d = INICIAL;
            end
        endcase
    end

    assign dado_serial = dado_serial_q;
    assign db_estado   = 4'(estado_q);

endmodule

// File: tb/tb_saida_serial_multidigito.sv
// Directed bench for saida_serial_multidigito: a 3-digit and a 4-digit instance
// share stimulus, with sel choosing which one is driven and observed.
module tb_saida_serial_multidigito;

`ifdef SAIDA_SERIAL_CRLF_EN
    localparam int CRLF_EXTRA = 2;
`else
    localparam int CRLF_EXTRA = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inicio = 1'b0;
    logic        suprime_zeros = 1'b0;
    logic        serial_enviado = 1'b0;
    logic        sel = 1'b0;
    logic [15:0] dados = 16'h0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    logic       p3, o3, r3, p4, o4, r4;
    logic [7:0] d3, d4;
    logic [3:0] e3, e4;
    logic       partida, ocupado, pronto;
    logic [7:0] dado_serial;
    logic [3:0] db_estado;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    saida_serial_multidigito #(.N_DIGITOS(3), .TERMINADOR(8'h23)) u3 (
        .clock(clock), .reset(reset), .inicio(inicio & ~sel), .dados(dados[11:0]),
        .suprime_zeros(suprime_zeros), .serial_enviado(serial_enviado & ~sel),
        .partida(p3), .dado_serial(d3), .ocupado(o3), .pronto(r3), .db_estado(e3));

    saida_serial_multidigito #(.N_DIGITOS(4), .TERMINADOR(8'h23)) u4 (
        .clock(clock), .reset(reset), .inicio(inicio & sel), .dados(dados),
        .suprime_zeros(suprime_zeros), .serial_enviado(serial_enviado & sel),
        .partida(p4), .dado_serial(d4), .ocupado(o4), .pronto(r4), .db_estado(e4));

    assign partida     = sel ? p4 : p3;
    assign ocupado     = sel ? o4 : o3;
    assign pronto      = sel ? r4 : r3;
    assign dado_serial = sel ? d4 : d3;
    assign db_estado   = sel ? e4 : e3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame with a transmitter that answers 4 cycles after each partida.
    // ev holds the nch expected characters, first one in the highest used byte.
    // stress: hold inicio/serial_enviado high and scramble dados until the first
    // partida. cortar: apply reset in ESPERA after that many characters.
    task automatic run_frame(input logic s, input logic [15:0] d, input logic sz,
                             input int nch, input logic [63:0] ev, input int lat0,
                             input logic stress, input int cortar);
        int         t;
        int         ts;
        int         n;
        logic [7:0] exp_c;
        logic       got;
        sel = s;
        @(negedge clock);
        dados = d; suprime_zeros = sz; inicio = 1'b1; serial_enviado = stress;
        t  = cyc;
        ts = cyc;
        n  = nch + CRLF_EXTRA;
        for (int i = 0; i < n; i++) begin
            if (i < nch) exp_c = ev[8*(nch-1-i) +: 8];
            else if (i == nch) exp_c = 8'h0D;
            else exp_c = 8'h0A;
            got = 1'b0;
            for (int w = 0; w < 30 && !got; w++) begin
                @(negedge clock);
                if (stress && i == 0) dados = ~d;
                else begin inicio = 1'b0; serial_enviado = 1'b0; end
                if (partida) got = 1'b1;
            end
            chk("partida_seen", 32'(got), 32'd1);
            if (!got) return;
            if (i == 0) chk("lat_first", 32'(cyc - t), 32'(lat0));
            else chk("lat_gap", 32'(cyc - ts), 32'd2);
            chk("char", 32'(dado_serial), 32'(exp_c));
            chk("state_envia", 32'(db_estado), 32'd2);
            if (cortar == i + 1) begin
                repeat (2) @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                chk("rst_partida", 32'(partida), 32'd0);
                chk("rst_pronto", 32'(pronto), 32'd0);
                chk("rst_ocupado", 32'(ocupado), 32'd0);
                chk("rst_dado", 32'(dado_serial), 32'd0);
                chk("rst_estado", 32'(db_estado), 32'd0);
                repeat (5) begin
                    @(negedge clock);
                    chk("rst_no_pronto", 32'(pronto), 32'd0);
                end
                return;
            end
            @(negedge clock);
            inicio = 1'b0; serial_enviado = 1'b0;
            chk("partida_width", 32'(partida), 32'd0);
            repeat (3) @(negedge clock);
            chk("hold_dado", 32'(dado_serial), 32'(exp_c));
            serial_enviado = 1'b1;
            ts = cyc;
        end
        @(negedge clock);
        serial_enviado = 1'b0;
        chk("pronto", 32'(pronto), 32'd1);
        chk("ocupado_fim", 32'(ocupado), 32'd1);
        @(negedge clock);
        chk("pronto_pulse", 32'(pronto), 32'd0);
        chk("ocupado_free", 32'(ocupado), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_partida", 32'(p3), 32'd0);
        chk("reset_pronto", 32'(r3), 32'd0);
        chk("reset_ocupado", 32'(o3), 32'd0);
        chk("reset_dado", 32'(d3), 32'd0);
        chk("reset_estado", 32'(e3), 32'd0);
        chk("reset_dado4", 32'(d4), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_ocupado", 32'(o3), 32'd0);

        run_frame(1'b0, 16'h0472, 1'b0, 4, 64'h34373223, 2, 1'b0, 0);
        run_frame(1'b1, 16'h0050, 1'b1, 3, 64'h353023,   4, 1'b0, 0);
        run_frame(1'b1, 16'h0000, 1'b1, 2, 64'h3023,     5, 1'b0, 0);
        run_frame(1'b1, 16'h1000, 1'b1, 5, 64'h3130303023, 2, 1'b0, 0);
        run_frame(1'b0, 16'h01A3, 1'b0, 4, 64'h313F3323, 2, 1'b0, 0);
        run_frame(1'b0, 16'h00A0, 1'b1, 3, 64'h3F3023,   3, 1'b0, 0);
        run_frame(1'b0, 16'h0472, 1'b0, 4, 64'h34373223, 2, 1'b1, 0);
        run_frame(1'b0, 16'h0472, 1'b0, 4, 64'h34373223, 2, 1'b0, 2);
        run_frame(1'b0, 16'h0472, 1'b0, 4, 64'h34373223, 2, 1'b0, 0);
`ifdef SAIDA_SERIAL_CRLF_EN
        run_frame(1'b0, 16'h0009, 1'b1, 2, 64'h3923,     4, 1'b0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
